// File: rtl/ex_wb_stage.sv
// ex_wb_stage: execute-to-writeback stage with load alignment; `define MISALIGN_TRAP_EN traps misaligned LH/LHU/LW
module ex_wb_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_result,
  input  logic [31:0] pc_plus4,
  input  logic [4:0]  rd_addr,
  input  logic        rf_we,
  input  logic [1:0]  wb_sel,
  input  logic [2:0]  load_funct3,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        flush,
  output logic        rf_wr_en,
  output logic [4:0]  rf_wr_addr,
  output logic [31:0] rf_wr_data,
  output logic        busy,
  output logic        misaligned
);
  typedef enum logic [1:0] {IDLE, WAIT_MEM, WB} state_t;
  state_t state, state_nx;
  logic [31:0] alu_q, pc4_q, ld_q, hold_data, wb_data, ld_aligned;
  logic [15:0] half;
  logic [7:0]  byte_v;
  logic [4:0]  rd_q, hold_addr;
  logic [2:0]  f3_q;
  logic [1:0]  sel_q;
  logic        we_q, mis_q, mis_d, acc, is_load;
  assign in_ready = state != WAIT_MEM && !flush;
  assign acc      = in_valid && in_ready;
  assign is_load  = wb_sel == 2'b01;
`ifdef MISALIGN_TRAP_EN
  assign mis_d = is_load && ((load_funct3[1:0] == 2'b01 && alu_result[0]) ||
                             (load_funct3 == 3'b010 && alu_result[1:0] != 2'b00));
  assign misaligned = state == WB && mis_q && !flush;
`else
  assign mis_d      = 1'b0;
  assign misaligned = 1'b0;
`endif
  // Byte/halfword lanes are picked by the captured effective address
  assign byte_v = mem_rdata[{alu_q[1:0], 3'b000} +: 8];
  assign half   = alu_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  assign ld_aligned = f3_q == 3'b000 ? {{24{byte_v[7]}}, byte_v} :
                      f3_q == 3'b100 ? {24'b0, byte_v} :
                      f3_q == 3'b001 ? {{16{half[15]}}, half} :
                      f3_q == 3'b101 ? {16'b0, half} : mem_rdata;
  assign wb_data    = sel_q == 2'b01 ? ld_q : sel_q == 2'b10 ? pc4_q : alu_q;
  assign rf_wr_en   = state == WB && !flush && we_q && rd_q != 5'd0 && !mis_q;
  assign rf_wr_addr = state == WB ? rd_q : hold_addr;
  assign rf_wr_data = state == WB ? wb_data : hold_data;
  assign busy       = state != IDLE;
  always_comb begin
    state_nx = IDLE;
    if (flush)
      state_nx = IDLE;
    else if (acc)
      state_nx = is_load && !mis_d ? WAIT_MEM : WB;
    else if (state == WAIT_MEM)
      state_nx = mem_rvalid ? WB : WAIT_MEM;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      alu_q     <= '0;
      pc4_q     <= '0;
      ld_q      <= '0;
      rd_q      <= '0;
      f3_q      <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      mis_q     <= 1'b0;
      hold_addr <= '0;
      hold_data <= '0;
    end else begin
      state <= state_nx;
      if (acc) begin
        alu_q <= alu_result;
        pc4_q <= pc_plus4;
        rd_q  <= rd_addr;
        f3_q  <= load_funct3;
        sel_q <= wb_sel;
        we_q  <= rf_we;
        mis_q <= mis_d;
      end
      if (state == WAIT_MEM && mem_rvalid && !flush)
        ld_q <= ld_aligned;
      if (state == WB) begin
        hold_addr <= rd_q;
        hold_data <= wb_data;
      end
    end
  end
endmodule
